// File: rtl/pa_cmd_arbiter_gen2.sv
// N-source DDRC command arbiter: two-class QoS with age promotion, atomic lock with timeout.
// Define PA_ARB_RR_EN for per-class round-robin; otherwise fixed priority (highest index wins).
module pa_cmd_arbiter_gen2 #(
  parameter int NUM_SRC  = 8,
  parameter int ID_W     = $clog2(NUM_SRC),
  parameter int AGE_W    = 6,
  parameter int LOCK_TMO = 64
) (
  input  logic               ddrc_clk,
  input  logic               ddrc_rst_n,
  input  logic               clk_en,
  input  logic [NUM_SRC-1:0] mask,
  input  logic [AGE_W-1:0]   age_th,
  input  logic [NUM_SRC-1:0] req_vld,
  input  logic [NUM_SRC-1:0] req_hqos,
  input  logic [NUM_SRC-1:0] req_lock,
  output logic [NUM_SRC-1:0] req_rdy,
  output logic               gnt_vld,
  output logic [ID_W-1:0]    gnt_id,
  output logic               gnt_hqos,
  output logic               lock_active,
  output logic [ID_W-1:0]    lock_owner,
  output logic               lock_err,
  output logic [NUM_SRC-1:0] starve_flag
);

  localparam int TMO_W = (LOCK_TMO > 1) ? $clog2(LOCK_TMO + 1) : 1;

  typedef enum logic {ST_IDLE, ST_LOCKED} lock_state_t;

  lock_state_t        lock_state;
  logic [AGE_W-1:0]   age_cnt [NUM_SRC];
  logic [TMO_W-1:0]   tmo_cnt;
  logic [NUM_SRC-1:0] elig;
  logic [NUM_SRC-1:0] hi;
  logic [NUM_SRC-1:0] hi_elig;
  logic [NUM_SRC-1:0] lo_elig;
  logic [NUM_SRC-1:0] cand;
  logic               use_hi;
  logic               any_cand;
  logic [ID_W-1:0]    sel_idx;
  logic               xfer;
  logic               sel_lock;
  logic               sel_hi;
  logic               tmo_hit;

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      starve_flag[i] = (age_th != '0) && (age_cnt[i] >= age_th);
    end
  end

  assign hi = req_hqos | starve_flag;

  // While locked only the owner may compete, and its mask bit is ignored.
  always_comb begin
    elig = '0;
    if (lock_state == ST_LOCKED) begin
      elig[lock_owner] = req_vld[lock_owner];
    end else begin
      elig = req_vld & ~mask;
    end
  end

  assign hi_elig  = elig & hi;
  assign lo_elig  = elig & ~hi;
  assign use_hi   = |hi_elig;
  assign cand     = use_hi ? hi_elig : lo_elig;
  assign any_cand = |cand;

`ifdef PA_ARB_RR_EN
  logic [ID_W-1:0] rr_ptr_hi;
  logic [ID_W-1:0] rr_ptr_lo;
  logic [ID_W-1:0] rr_base;

  // Scan upward from one past the last winner of the active class, wrapping.
  always_comb begin
    int   idx;
    logic found;
    idx     = 0;
    found   = 1'b0;
    sel_idx = '0;
    rr_base = use_hi ? rr_ptr_hi : rr_ptr_lo;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx = (int'(rr_base) + k) % NUM_SRC;
      if (!found && cand[idx]) begin
        sel_idx = ID_W'(idx);
        found   = 1'b1;
      end
    end
  end

  always_ff @(posedge ddrc_clk) begin
    if (!ddrc_rst_n) begin
      rr_ptr_hi <= '0;
      rr_ptr_lo <= '0;
    end else if (xfer) begin
      if (sel_hi) begin
        rr_ptr_hi <= sel_idx;
      end else begin
        rr_ptr_lo <= sel_idx;
      end
    end
  end
`else
  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (cand[i]) begin
        sel_idx = ID_W'(i);
      end
    end
  end
`endif

  always_comb begin
    req_rdy = '0;
    if (ddrc_rst_n && clk_en && any_cand) begin
      req_rdy[sel_idx] = 1'b1;
    end
  end

  assign xfer     = |(req_vld & req_rdy);
  assign sel_lock = req_lock[sel_idx];
  assign sel_hi   = hi[sel_idx];
  assign tmo_hit  = (LOCK_TMO != 0) && (int'(tmo_cnt) == LOCK_TMO - 1);

  always_ff @(posedge ddrc_clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!ddrc_rst_n) begin
        age_cnt[i] <= '0;
      end else if (clk_en) begin
        if (!req_vld[i] || req_rdy[i]) begin
          age_cnt[i] <= '0;
        end else if (age_cnt[i] != {AGE_W{1'b1}}) begin
          age_cnt[i] <= age_cnt[i] + 1'b1;
        end
      end
    end
  end

  // An owner transfer in the timeout cycle takes precedence, so no error is raised.
  always_ff @(posedge ddrc_clk) begin
    if (!ddrc_rst_n) begin
      lock_state <= ST_IDLE;
      lock_owner <= '0;
      tmo_cnt    <= '0;
      lock_err   <= 1'b0;
    end else begin
      lock_err <= 1'b0;
      if (clk_en) begin
        case (lock_state)
          ST_IDLE: begin
            if (xfer && sel_lock) begin
              lock_state <= ST_LOCKED;
              lock_owner <= sel_idx;
              tmo_cnt    <= '0;
            end
          end
          ST_LOCKED: begin
            if (xfer) begin
              tmo_cnt <= '0;
              if (!sel_lock) begin
                lock_state <= ST_IDLE;
                lock_owner <= '0;
              end
            end else if (tmo_hit) begin
              lock_state <= ST_IDLE;
              lock_owner <= '0;
              tmo_cnt    <= '0;
              lock_err   <= 1'b1;
            end else if (LOCK_TMO != 0) begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end
          default: begin
            lock_state <= ST_IDLE;
            lock_owner <= '0;
            tmo_cnt    <= '0;
          end
        endcase
      end
    end
  end

  assign lock_active = (lock_state == ST_LOCKED);

  always_ff @(posedge ddrc_clk) begin
    if (!ddrc_rst_n) begin
      gnt_vld  <= 1'b0;
      gnt_id   <= '0;
      gnt_hqos <= 1'b0;
    end else begin
      gnt_vld  <= xfer;
      gnt_id   <= xfer ? sel_idx : '0;
      gnt_hqos <= xfer & sel_hi;
    end
  end

endmodule
